// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default HALT drain length.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hazard_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;

    // The drain counter only ever holds DRAIN_CYCLES-1 down to 0.
    function automatic int drain_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational operand compare: EX/MEM stall hazards and the
// MEM-to-ID forward selects for the operands consumed in ID.
module hazard_detect #(
    parameter int NB_ADDR = 5
) (
    input  logic [NB_ADDR-1:0] i_id_rs_addr,
    input  logic [NB_ADDR-1:0] i_id_rt_addr,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    input  logic               i_id_is_branch,
    input  logic               i_ex_regWrite,
    input  logic               i_ex_memRead,
    input  logic [NB_ADDR-1:0] i_ex_wb_addr,
    input  logic               i_mem_regWrite,
    input  logic               i_mem_memRead,
    input  logic [NB_ADDR-1:0] i_mem_wb_addr,
    output logic               o_hz_ex,
    output logic               o_hz_mem,
    output logic               o_forwardA,
    output logic               o_forwardB
);

    logic ex_dst_live, ex_match;
    logic mem_dst_live, mem_rs_match, mem_rt_match;

    // Register 0 is hardwired, so a $0 destination never creates a dependency.
    assign ex_dst_live  = i_ex_regWrite & (i_ex_wb_addr != '0);
    assign ex_match     = (i_id_uses_rs & (i_ex_wb_addr == i_id_rs_addr)) |
                          (i_id_uses_rt & (i_ex_wb_addr == i_id_rt_addr));

    assign mem_dst_live = i_mem_regWrite & (i_mem_wb_addr != '0);
    assign mem_rs_match = i_id_uses_rs & (i_mem_wb_addr == i_id_rs_addr);
    assign mem_rt_match = i_id_uses_rt & (i_mem_wb_addr == i_id_rt_addr);

    assign o_hz_ex    = ex_dst_live & ex_match & (i_ex_memRead | i_id_is_branch);
    assign o_hz_mem   = i_id_is_branch & i_mem_memRead & mem_dst_live &
                        (mem_rs_match | mem_rt_match);

    // Load data is not available in MEM yet, so only ALU results forward.
    assign o_forwardA = mem_dst_live & ~i_mem_memRead & mem_rs_match;
    assign o_forwardB = mem_dst_live & ~i_mem_memRead & mem_rt_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/halt controller with MEM-to-ID forwarding. Define
// HAZARD_STALL_CNT_EN to build the saturating hazard-stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NB_ADDR      = 5,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dunit_clk_en,
    input  logic [NB_ADDR-1:0] i_id_rs_addr,
    input  logic [NB_ADDR-1:0] i_id_rt_addr,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    input  logic               i_id_is_branch,
    input  logic               i_id_halt,
    input  logic               i_ex_regWrite,
    input  logic               i_ex_memRead,
    input  logic [NB_ADDR-1:0] i_ex_wb_addr,
    input  logic               i_mem_regWrite,
    input  logic               i_mem_memRead,
    input  logic [NB_ADDR-1:0] i_mem_wb_addr,
    output logic               o_forwardA,
    output logic               o_forwardB,
    output logic               o_pc_write,
    output logic               o_ifid_write,
    output logic               o_idex_bubble,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_stall_count,
    output hazard_state_e      o_state
);

    localparam int NB_DRAIN = drain_cnt_width(DRAIN_CYCLES);

    hazard_state_e       state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                hz_ex, hz_mem, hazard;

    hazard_detect #(.NB_ADDR(NB_ADDR)) u_detect (
        .i_id_rs_addr   (i_id_rs_addr),
        .i_id_rt_addr   (i_id_rt_addr),
        .i_id_uses_rs   (i_id_uses_rs),
        .i_id_uses_rt   (i_id_uses_rt),
        .i_id_is_branch (i_id_is_branch),
        .i_ex_regWrite  (i_ex_regWrite),
        .i_ex_memRead   (i_ex_memRead),
        .i_ex_wb_addr   (i_ex_wb_addr),
        .i_mem_regWrite (i_mem_regWrite),
        .i_mem_memRead  (i_mem_memRead),
        .i_mem_wb_addr  (i_mem_wb_addr),
        .o_hz_ex        (hz_ex),
        .o_hz_mem       (hz_mem),
        .o_forwardA     (o_forwardA),
        .o_forwardB     (o_forwardB)
    );

    assign hazard  = hz_ex | hz_mem;
    assign o_state = state;

    // Pipeline enables follow the current cycle's hazard, so they stay combinational.
    always_comb begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b0;
        if (i_dunit_clk_en) begin
            case (state)
                ST_RUN: begin
                    if (hazard || i_id_halt) begin
                        o_idex_bubble = 1'b1;
                    end else begin
                        o_pc_write   = 1'b1;
                        o_ifid_write = 1'b1;
                    end
                end
                default: o_idex_bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            o_halted  <= 1'b0;
        end else if (i_dunit_clk_en) begin
            case (state)
                ST_RUN: begin
                    // A stalled HALT waits in ID until its operands clear.
                    if (!hazard && i_id_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= ST_HALTED;
                        o_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [NB_CNT-1:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt <= '0;
        end else if (i_dunit_clk_en && state == ST_RUN && hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign o_stall_count = stall_cnt;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scenario tasks push expected control
// vectors; a negedge scoreboard pops and compares them.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int NB_ADDR = 5;
  localparam int NB_CNT  = 32;
  localparam int W       = 6;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               en;
  logic [NB_ADDR-1:0] rs_addr, rt_addr, ex_wa, mem_wa;
  logic               uses_rs, uses_rt, is_branch, id_halt;
  logic               ex_rw, ex_mr, mem_rw, mem_mr;
  logic               fwd_a, fwd_b, pc_write, ifid_write, idex_bubble, halted;
  logic [NB_CNT-1:0]  stall_count;
  hazard_state_e      state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_fail;
  int           exp_stall;
  logic [W-1:0] sb_exp, sb_got;
  string        sb_name;

  hazard_ctrl #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT), .DRAIN_CYCLES(3)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_dunit_clk_en (en),
    .i_id_rs_addr   (rs_addr),
    .i_id_rt_addr   (rt_addr),
    .i_id_uses_rs   (uses_rs),
    .i_id_uses_rt   (uses_rt),
    .i_id_is_branch (is_branch),
    .i_id_halt      (id_halt),
    .i_ex_regWrite  (ex_rw),
    .i_ex_memRead   (ex_mr),
    .i_ex_wb_addr   (ex_wa),
    .i_mem_regWrite (mem_rw),
    .i_mem_memRead  (mem_mr),
    .i_mem_wb_addr  (mem_wa),
    .o_forwardA     (fwd_a),
    .o_forwardB     (fwd_b),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_idex_bubble  (idex_bubble),
    .o_halted       (halted),
    .o_stall_count  (stall_count),
    .o_state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // scoreboard: expected vector is {pc_write, ifid_write, bubble, fwdA, fwdB, halted}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp  = exp_q.pop_front();
      sb_name = name_q.pop_front();
      sb_got  = {pc_write, ifid_write, idex_bubble, fwd_a, fwd_b, halted};
      n_checks++;
      if (sb_got !== sb_exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", sb_name, sb_got, sb_exp);
      end
    end
  end

  function automatic logic [W-1:0] ev(input bit pc, ifid, bub, fa, fb, h);
    return {pc, ifid, bub, fa, fb, h};
  endfunction

  // driver tasks
  task automatic idle();
    rst = 1'b0; en = 1'b1;
    rs_addr = '0; rt_addr = '0; uses_rs = 1'b0; uses_rt = 1'b0;
    is_branch = 1'b0; id_halt = 1'b0;
    ex_rw = 1'b0; ex_mr = 1'b0; ex_wa = '0;
    mem_rw = 1'b0; mem_mr = 1'b0; mem_wa = '0;
  endtask

  // Inputs are set just after a posedge; the cycle is scored at the negedge.
  task automatic step(input string name, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (state !== ST_RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, ST_RUN); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_checks++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    step("reset_idle_run", ev(1, 1, 0, 0, 0, 0));
  endtask

  task automatic test_load_use();
    idle();
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd2;
    rs_addr = 5'd2; rt_addr = 5'd4; uses_rs = 1'b1; uses_rt = 1'b1;
    step("load_use_stall", ev(0, 0, 1, 0, 0, 0));
    exp_stall++;
    ex_rw = 1'b0; ex_mr = 1'b0; ex_wa = '0;
    mem_rw = 1'b1; mem_mr = 1'b1; mem_wa = 5'd2;
    step("load_use_resume", ev(1, 1, 0, 0, 0, 0));
    n_checks++;
    if (stall_count !== (CNT_EN ? NB_CNT'(exp_stall) : '0)) begin
      n_fail++; $display("FAIL load_use_count: got %0d expected %0d", stall_count, CNT_EN ? exp_stall : 0);
    end
  endtask

  task automatic test_branch_fwd();
    idle();
    ex_rw = 1'b1; ex_wa = 5'd5;
    rs_addr = 5'd5; rt_addr = 5'd6; uses_rs = 1'b1; uses_rt = 1'b1; is_branch = 1'b1;
    step("branch_ex_stall", ev(0, 0, 1, 0, 0, 0));
    exp_stall++;
    ex_rw = 1'b0; ex_wa = '0;
    mem_rw = 1'b1; mem_wa = 5'd5;
    step("branch_mem_forward", ev(1, 1, 0, 1, 0, 0));
  endtask

  task automatic test_load_branch();
    idle();
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd7;
    rs_addr = 5'd7; rt_addr = 5'd0; uses_rs = 1'b1; uses_rt = 1'b1; is_branch = 1'b1;
    step("load_branch_stall1", ev(0, 0, 1, 0, 0, 0));
    ex_rw = 1'b0; ex_mr = 1'b0; ex_wa = '0;
    mem_rw = 1'b1; mem_mr = 1'b1; mem_wa = 5'd7;
    step("load_branch_stall2", ev(0, 0, 1, 0, 0, 0));
    exp_stall += 2;
    mem_rw = 1'b0; mem_mr = 1'b0; mem_wa = '0;
    step("load_branch_resume", ev(1, 1, 0, 0, 0, 0));
    n_checks++;
    if (stall_count !== (CNT_EN ? NB_CNT'(exp_stall) : '0)) begin
      n_fail++; $display("FAIL load_branch_count: got %0d expected %0d", stall_count, CNT_EN ? exp_stall : 0);
    end
  endtask

  task automatic test_reg_zero();
    idle();
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd0;
    mem_rw = 1'b1; mem_wa = 5'd0;
    uses_rs = 1'b1; uses_rt = 1'b1; is_branch = 1'b1;
    step("reg_zero_no_stall", ev(1, 1, 0, 0, 0, 0));
    idle();
    mem_rw = 1'b1; mem_wa = 5'd9;
    rs_addr = 5'd9; rt_addr = 5'd9; uses_rs = 1'b0; uses_rt = 1'b1;
    step("forward_b_only", ev(1, 1, 0, 0, 1, 0));
  endtask

  task automatic test_disable();
    idle();
    en = 1'b0;
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd3;
    rs_addr = 5'd3; uses_rs = 1'b1;
    mem_rw = 1'b1; mem_wa = 5'd4; rt_addr = 5'd4; uses_rt = 1'b1;
    step("disabled_hazard", ev(0, 0, 0, 0, 1, 0));
    n_checks++;
    if (stall_count !== (CNT_EN ? NB_CNT'(exp_stall) : '0)) begin
      n_fail++; $display("FAIL disabled_count: got %0d expected %0d", stall_count, CNT_EN ? exp_stall : 0);
    end
  endtask

  task automatic test_random_fwd();
    bit fa, fb;
    for (int i = 0; i < 24; i++) begin
      idle();
      en      = 1'b0;
      rs_addr = NB_ADDR'($urandom_range(0, 3));
      rt_addr = NB_ADDR'($urandom_range(0, 3));
      uses_rs = 1'($urandom_range(0, 1));
      uses_rt = 1'($urandom_range(0, 1));
      mem_rw  = 1'($urandom_range(0, 1));
      mem_mr  = 1'($urandom_range(0, 1));
      mem_wa  = NB_ADDR'($urandom_range(0, 3));
      ex_rw   = 1'($urandom_range(0, 1));
      ex_mr   = 1'($urandom_range(0, 1));
      ex_wa   = NB_ADDR'($urandom_range(0, 3));
      is_branch = 1'($urandom_range(0, 1));
      fa = mem_rw && !mem_mr && mem_wa != 0 && mem_wa == rs_addr && uses_rs;
      fb = mem_rw && !mem_mr && mem_wa != 0 && mem_wa == rt_addr && uses_rt;
      step("random_forward", ev(0, 0, 0, fa, fb, 0));
    end
    n_checks++;
    if (state !== ST_RUN) begin n_fail++; $display("FAIL random_state_held: got %0d expected %0d", state, ST_RUN); end
  endtask

  task automatic test_halt_drain();
    idle();
    id_halt = 1'b1;
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd8; rs_addr = 5'd8; uses_rs = 1'b1;
    step("halt_behind_hazard", ev(0, 0, 1, 0, 0, 0));
    exp_stall++;
    n_checks++;
    if (state !== ST_RUN) begin n_fail++; $display("FAIL hazard_priority_state: got %0d expected %0d", state, ST_RUN); end
    idle();
    id_halt = 1'b1;
    step("halt_enter", ev(0, 0, 1, 0, 0, 0));
    n_checks++;
    if (state !== ST_DRAIN) begin n_fail++; $display("FAIL drain_entry_state: got %0d expected %0d", state, ST_DRAIN); end
    id_halt = 1'b0;
    step("drain_1", ev(0, 0, 1, 0, 0, 0));
    en = 1'b0;
    repeat (5) step("drain_frozen", ev(0, 0, 0, 0, 0, 0));
    n_checks++;
    if (state !== ST_DRAIN) begin n_fail++; $display("FAIL frozen_state: got %0d expected %0d", state, ST_DRAIN); end
    en = 1'b1;
    step("drain_2", ev(0, 0, 1, 0, 0, 0));
    step("drain_3", ev(0, 0, 1, 0, 0, 0));
    n_checks++;
    if (state !== ST_HALTED) begin n_fail++; $display("FAIL halted_state: got %0d expected %0d", state, ST_HALTED); end
    ex_rw = 1'b1; ex_mr = 1'b1; ex_wa = 5'd8; rs_addr = 5'd8; uses_rs = 1'b1;
    step("halted_with_hazard", ev(0, 0, 1, 0, 0, 1));
    step("halted_sticky", ev(0, 0, 1, 0, 0, 1));
    en = 1'b0;
    step("halted_disabled", ev(0, 0, 0, 0, 0, 1));
    n_checks++;
    if (stall_count !== (CNT_EN ? NB_CNT'(exp_stall) : '0)) begin
      n_fail++; $display("FAIL halted_count: got %0d expected %0d", stall_count, CNT_EN ? exp_stall : 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_stall = 0;
    n_checks++;
    if (state !== ST_RUN || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_from_halted: got state %0d halted %b expected %0d 0", state, halted, ST_RUN);
    end
    n_checks++;
    if (stall_count !== '0) begin n_fail++; $display("FAIL reset_clears_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_reset_mid_drain();
    idle();
    id_halt = 1'b1;
    step("halt_enter_again", ev(0, 0, 1, 0, 0, 0));
    id_halt = 1'b0;
    step("drain_before_reset", ev(0, 0, 1, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (state !== ST_RUN || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_drain: got state %0d halted %b expected %0d 0", state, halted, ST_RUN);
    end
    repeat (4) step("run_after_reset", ev(1, 1, 0, 0, 0, 0));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch_fwd();
    test_load_branch();
    test_reg_zero();
    test_disable();
    test_random_fwd();
    test_halt_drain();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
